// File: rtl/token_delay_register_if.sv
// Ready/valid token channel: upstream (in_*) and downstream (out_*) handshakes.
// The block under control uses the slave view; its environment uses the master view.
interface token_delay_register_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_bits;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_bits;

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits
  );

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits
  );
endinterface

// File: rtl/token_delay_register.sv
// Circular-buffer token FIFO preloaded with INIT_TOKENS copies of INIT_VALUE at reset.
// Handshake flags come only from registered occupancy, so there is no in->out bypass.
module token_delay_register #(
  parameter int              DATA_WIDTH  = 8,
  parameter logic [63:0]     INIT_VALUE  = 64'd0,
  parameter int              INIT_TOKENS = 1,
  parameter int              DEPTH       = 4,
  localparam int             AW          = $clog2(DEPTH),
  localparam int             OW          = AW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  token_delay_register_if.slave tok,
  output logic [OW-1:0]        occupancy,
  output logic [31:0]          enq_count,
  output logic [31:0]          deq_count
);

  localparam logic [OW-1:0]         FULL_OCC  = OW'(DEPTH);
  localparam logic [OW-1:0]         INIT_OCC  = OW'(INIT_TOKENS);
  localparam logic [AW-1:0]         INIT_WR   = AW'(INIT_TOKENS % DEPTH);
  localparam logic [DATA_WIDTH-1:0] INIT_DATA = INIT_VALUE[DATA_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]         rd_reg;
  logic [AW-1:0]         wr_reg;
  logic [OW-1:0]         occ_reg;
  logic [OW-1:0]         occ_next;
  logic [31:0]           enq_reg;
  logic [31:0]           deq_reg;
  logic                  in_ready_w;
  logic                  out_valid_w;
  logic                  enq_fire;
  logic                  deq_fire;

  assign in_ready_w  = (occ_reg != FULL_OCC);
  assign out_valid_w = (occ_reg != '0);
  assign enq_fire    = tok.in_valid & in_ready_w;
  assign deq_fire    = tok.out_ready & out_valid_w;

  assign tok.in_ready  = in_ready_w;
  assign tok.out_valid = out_valid_w;
  assign tok.out_bits  = mem_reg[rd_reg];

  assign occupancy = occ_reg;
  assign enq_count = enq_reg;
  assign deq_count = deq_reg;

  always_comb begin
    occ_next = occ_reg;
    case ({enq_fire, deq_fire})
      2'b10:   occ_next = occ_reg + OW'(1);
      2'b01:   occ_next = occ_reg - OW'(1);
      default: occ_next = occ_reg;
    endcase
  end

  // Reset reloads the preloaded entries; the rest keep stale data (never visible).
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i < INIT_TOKENS) begin
          mem_reg[i] <= INIT_DATA;
        end
      end
    end else if (enq_fire) begin
      mem_reg[wr_reg] <= tok.in_bits;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_reg  <= '0;
      wr_reg  <= INIT_WR;
      occ_reg <= INIT_OCC;
      enq_reg <= '0;
      deq_reg <= '0;
    end else begin
      occ_reg <= occ_next;
      if (enq_fire) begin
        wr_reg  <= wr_reg + AW'(1);
        enq_reg <= enq_reg + 32'd1;
      end
      if (deq_fire) begin
        rd_reg  <= rd_reg + AW'(1);
        deq_reg <= deq_reg + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_token_delay_register.sv
// Scoreboarded bench: a reference model queues expected tokens, a monitor pops on each dequeue.
// A second instance with no preloaded tokens covers the empty-start behaviour.
module tb_token_delay_register;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  token_delay_register_if #(.DATA_WIDTH(8)) ifa ();
  token_delay_register_if #(.DATA_WIDTH(8)) ifb ();

  logic [2:0]  occ_a, occ_b;
  logic [31:0] enq_a, deq_a, enq_b, deq_b;

  token_delay_register #(
    .DATA_WIDTH(8), .INIT_VALUE(64'h5A), .INIT_TOKENS(1), .DEPTH(4)
  ) dut_a (
    .clock(clock), .reset(reset), .tok(ifa),
    .occupancy(occ_a), .enq_count(enq_a), .deq_count(deq_a)
  );

  token_delay_register #(
    .DATA_WIDTH(8), .INIT_VALUE(64'h5A), .INIT_TOKENS(0), .DEPTH(4)
  ) dut_b (
    .clock(clock), .reset(reset), .tok(ifb),
    .occupancy(occ_b), .enq_count(enq_b), .deq_count(deq_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model for dut_a, advanced on each posedge from its own state.
  logic [7:0]  exp_q [$];
  logic [7:0]  seen  [$];
  int          m_occ = 0;
  logic [31:0] m_enq = 0;
  logic [31:0] m_deq = 0;
  bit          m_ok  = 1'b0;
  bit          m_e, m_d;

  always @(posedge clock) begin
    if (reset === 1'b1) begin
      exp_q.delete();
      exp_q.push_back(8'h5A);
      m_occ = 1;
      m_enq = 0;
      m_deq = 0;
      m_ok  = 1'b1;
    end else if (m_ok) begin
      m_e = (ifa.in_valid === 1'b1) && (m_occ < 4);
      m_d = (ifa.out_ready === 1'b1) && (m_occ > 0);
      if (m_e) begin
        exp_q.push_back(ifa.in_bits);
        m_enq++;
      end
      if (m_d) m_deq++;
      m_occ = m_occ + int'(m_e) - int'(m_d);
    end
  end

  // Per-cycle flag/counter checks against the model.
  always @(negedge clock) begin
    if (m_ok) begin
      chk("in_ready",  32'(ifa.in_ready),  32'(m_occ < 4));
      chk("out_valid", 32'(ifa.out_valid), 32'(m_occ > 0));
      chk("occupancy", 32'(occ_a), 32'(m_occ));
      chk("enq_count", enq_a, m_enq);
      chk("deq_count", deq_a, m_deq);
      chk("occ_invariant", 32'(occ_a), 32'd1 + enq_a - deq_a);
    end
  end

  // Monitor: every dequeue must match the head of the expected queue.
  always @(negedge clock) begin
    if (m_ok && ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got token %0h expected no token", ifa.out_bits);
      end else begin
        chk("sb_data", 32'(ifa.out_bits), 32'(exp_q.pop_front()));
      end
      seen.push_back(ifa.out_bits);
    end
  end

  task automatic cyc(input logic iv, input logic [7:0] ib, input logic ordy, input logic rst);
    ifa.in_valid  = iv;
    ifa.in_bits   = ib;
    ifa.out_ready = ordy;
    reset         = rst;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] seen_at(input int i);
    return (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] order36 [4];
    int         cycles;
    order36 = '{8'h5A, 8'h01, 8'h02, 8'h03};

    reset = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_bits = 8'h00; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_bits = 8'h00; ifb.out_ready = 1'b0;
    @(posedge clock);
    #1;

    chk("rst_occ_a",      32'(occ_a), 32'd1);
    chk("rst_out_valid_a", 32'(ifa.out_valid), 32'd1);
    chk("rst_out_bits_a", 32'(ifa.out_bits), 32'h5A);
    chk("rst_in_ready_a", 32'(ifa.in_ready), 32'd1);
    chk("rst_out_valid_b", 32'(ifb.out_valid), 32'd0);
    chk("rst_in_ready_b", 32'(ifb.in_ready), 32'd1);

    // Empty instance: an enqueue is not visible until the following cycle.
    reset = 1'b0;
    ifb.in_valid = 1'b1; ifb.in_bits = 8'h77; ifb.out_ready = 1'b1;
    #1;
    chk("b_no_bypass", 32'(ifb.out_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    ifb.in_valid = 1'b0;
    #1;
    chk("b_out_valid", 32'(ifb.out_valid), 32'd1);
    chk("b_out_bits",  32'(ifb.out_bits), 32'h77);
    chk("b_occ",       32'(occ_b), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("b_drained",   32'(ifb.out_valid), 32'd0);
    chk("b_deq_count", deq_b, 32'd1);
    ifb.out_ready = 1'b0;

    // Preloaded token drains on the first ready cycle.
    seen.delete();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("r35_out_valid", 32'(ifa.out_valid), 32'd0);
    chk("r35_deq_count", deq_a, 32'd1);
    chk("r35_token",     seen_at(0), 32'h5A);

    // Fill to full behind the preloaded token.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    seen.delete();
    cyc(1'b1, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    chk("full_occ",      32'(occ_a), 32'd4);
    chk("full_in_ready", 32'(ifa.in_ready), 32'd0);

    // Full with both sides active: only the dequeue happens.
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("r37_occ",      32'(occ_a), 32'd3);
    chk("r37_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("r37_enq",      enq_a, 32'd3);

    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_occ",   32'(occ_a), 32'd0);
    chk("drain_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("drain_order%0d", i), seen_at(i), 32'(order36[i]));

    // Mid-operation reset, with simultaneous enqueue and dequeue requests.
    cyc(1'b1, 8'h10, 1'b0, 1'b0);
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h12, 1'b0, 1'b0);
    chk("r40_pre_occ",  32'(occ_a), 32'd3);
    chk("r40_pre_bits", 32'(ifa.out_bits), 32'h10);
    cyc(1'b1, 8'h99, 1'b1, 1'b1);
    chk("r40_occ",      32'(occ_a), 32'd1);
    chk("r40_bits",     32'(ifa.out_bits), 32'h5A);
    chk("r40_enq",      enq_a, 32'd0);
    chk("r40_deq",      deq_a, 32'd0);
    chk("r40_in_ready", 32'(ifa.in_ready), 32'd1);

    // Random-handshake streaming of 1000 tokens, then drain.
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    seen.delete();
    cycles = 0;
    while (m_enq < 32'd1000 && cycles < 20000) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      cycles++;
    end
    cycles = 0;
    while (m_occ > 0 && cycles < 20) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cycles++;
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stream_enq",    enq_a, 32'd1000);
    chk("stream_deq",    deq_a, 32'd1001);
    chk("stream_seen",   32'(seen.size()), 32'd1001);
    chk("stream_left",   32'(exp_q.size()), 32'd0);
    chk("stream_empty",  32'(ifa.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/token_delay_register.md
TOKEN_DELAY_REGISTER -- requirements
Module: token_delay_register

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of token payload, 1..64.
REQ-002 Parameter INIT_VALUE, default 0: payload of every preloaded token, truncated to DATA_WIDTH.
REQ-003 Parameter INIT_TOKENS, default 1: tokens preloaded at reset, 0..DEPTH-1.
REQ-004 Parameter DEPTH, default 4: token storage entries, power of two, 2..64.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clock  input  1  sole clock, all state updates on posedge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 in_valid  input  1  upstream offers a token.
REQ-009 in_ready  output  1  block accepts a token this cycle.
REQ-010 in_bits  input  DATA_WIDTH  payload of offered token.
REQ-011 out_valid  output  1  block offers a token downstream.
REQ-012 out_ready  input  1  downstream accepts offered token.
REQ-013 out_bits  output  DATA_WIDTH  payload of head token.
REQ-014 occupancy  output  clog2(DEPTH)+1  tokens currently held.
REQ-015 enq_count  output  32  tokens accepted since reset.
REQ-016 deq_count  output  32  tokens emitted since reset.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH entries with read pointer rd, write pointer wr, each clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-018 Enqueue fire = in_valid & in_ready; on fire, mem[wr] <= in_bits, wr increments.
REQ-019 Dequeue fire = out_valid & out_ready; on fire, rd increments.
REQ-020 in_ready SHALL be (occupancy < DEPTH), depending only on registered state, never on out_ready.
REQ-021 out_valid SHALL be (occupancy > 0); out_bits SHALL be mem[rd] combinationally; out_bits when out_valid=0 is don't-care.
REQ-022 No input-to-output bypass: a token accepted in cycle N SHALL be visible on out_bits no earlier than cycle N+1.
REQ-023 Tokens SHALL emerge in strict FIFO order, preloaded tokens first.
REQ-024 Occupancy: +1 on enqueue only, -1 on dequeue only, unchanged on simultaneous enqueue and dequeue.
REQ-025 When full (occupancy = DEPTH), in_ready = 0; simultaneous dequeue does not raise in_ready in that cycle.
REQ-026 When empty, out_valid = 0; simultaneous enqueue does not raise out_valid in that cycle.
REQ-027 enq_count and deq_count SHALL increment by 1 on respective fire and wrap 2^32-1 -> 0.
REQ-028 At all times occupancy SHALL equal INIT_TOKENS + enq_count - deq_count (mod 2^32).
REQ-029 in_bits SHALL be ignored when in_valid = 0; out_ready ignored when out_valid = 0.

Reset
REQ-030 Reset asserted at a posedge SHALL set rd = 0, wr = INIT_TOKENS mod DEPTH, occupancy = INIT_TOKENS, enq_count = 0, deq_count = 0.
REQ-031 Reset SHALL write INIT_VALUE into entries 0..INIT_TOKENS-1; other entries undefined.
REQ-032 In the cycle after reset: out_valid = (INIT_TOKENS > 0), out_bits = INIT_VALUE if valid, in_ready = 1.
REQ-033 Reset mid-operation SHALL discard all held tokens and fires in that cycle, and reload per REQ-030/031.
REQ-034 Reset SHALL take priority over any simultaneous enqueue or dequeue.

Verification
REQ-035 DW=8, INIT=0x5A, INIT_TOKENS=1, DEPTH=4; after reset out_ready=1, in_valid=0 -> one token 0x5A, then out_valid=0, deq_count=1.
REQ-036 Same config, push 0x01..0x03 while out_ready=0 -> occupancy 4, in_ready=0; drain -> 0x5A,0x01,0x02,0x03.
REQ-037 Full (occupancy 4), in_valid=1, out_ready=1 same cycle -> enq not taken, one dequeue, next cycle occupancy 3, in_ready=1.
REQ-038 INIT_TOKENS=0, empty, in_valid=1 in_bits=0x77 out_ready=1 -> out_valid=0 that cycle, out_bits=0x77 with out_valid=1 next cycle.
REQ-039 Continuous streaming 1000 tokens, in_valid and out_ready random 50% -> ordered output, REQ-028 holds every cycle, no loss or duplication.
REQ-040 Occupancy 3 with payloads 0x10..0x12, assert reset one cycle -> next cycle occupancy 1, out_bits 0x5A, counters 0.
